// File: rtl/nes_poll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nes_poll_scheduler
// Purpose  : Drives the shared NES controller bus (latch + shift clock) for
//            two controller ports wired in parallel. Both data lines are
//            shifted in during the same bus transaction. The block publishes
//            an active-high button snapshot, press-edge vectors and a
//            presence mask with a one-cycle valid strobe.
// Ports    : clk, reset_n (async, active-low)
//            poll_req            - request one poll (level or pulse)
//            nes_data0/1         - serial data, active-low (0 = pressed)
//            nes_latch, nes_clk  - shared controller bus outputs
//            buttons0/1          - active-high button state (bit0 A .. bit7 right)
//            pressed0/1          - 0->1 button edges of the latest snapshot
//            present             - bit n set when a controller is detected on port n
//            snap_valid          - one-cycle strobe for a new snapshot
//            busy                - poll in progress
// Config   : NES_AUTOPOLL_EN - when defined, a free-running timer issues a
//            poll request every POLL_PERIOD clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module nes_poll_scheduler #(
  parameter int unsigned LATCH_CYCLES    = 600,
  parameter int unsigned HALF_BIT_CYCLES = 300,
  parameter int unsigned POLL_PERIOD     = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       poll_req,
  input  logic       nes_data0,
  input  logic       nes_data1,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic [7:0] pressed0,
  output logic [7:0] pressed1,
  output logic [1:0] present,
  output logic       snap_valid,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_WAIT_A   = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_SHIFT_LO = 3'd4,
    S_PUBLISH  = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic            pending, pending_next;
  logic [1:0]      sync0, sync1;
  logic [7:0]      samp0, samp1;
  logic            req;
  logic            sample_a;
  logic            sample_bit;
  logic [7:0]      new_btn0, new_btn1;

  // --------------------------------------------------------------------------
  // Optional autopoll timer
  // --------------------------------------------------------------------------
  logic auto_req;
`ifdef NES_AUTOPOLL_EN
  localparam int unsigned TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(POLL_PERIOD - 1);
  logic [TW-1:0] tmr;

  // Free-running; deliberately not resynchronised by poll_req.
  assign auto_req = (tmr == TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr <= '0;
    end else if (auto_req) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TW'(1);
    end
  end
`else
  assign auto_req = 1'b0;
`endif

  assign req = poll_req | auto_req;

  // --------------------------------------------------------------------------
  // Data line synchronisers (idle level is high = not pressed)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= 2'b11;
      sync1 <= 2'b11;
    end else begin
      sync0 <= {sync0[0], nes_data0};
      sync1 <= {sync1[0], nes_data1};
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= 3'd0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_cnt_next;
      pending <= pending_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_cnt_next = bit_cnt;
    pending_next = pending;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (req || pending) begin
          state_next   = S_LATCH;
          pending_next = 1'b0;
        end
      end
      S_LATCH: begin
        if (req) pending_next = 1'b1;
        if (cnt == LATCH_LAST) begin
          cnt_next   = '0;
          state_next = S_WAIT_A;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_WAIT_A: begin
        if (req) pending_next = 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_cnt_next = 3'd1;
          state_next   = S_SHIFT_HI;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_SHIFT_HI: begin
        if (req) pending_next = 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = S_SHIFT_LO;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_SHIFT_LO: begin
        if (req) pending_next = 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = S_PUBLISH;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            state_next   = S_SHIFT_HI;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_PUBLISH: begin
        cnt_next = '0;
        // A held flag is consumed here (any request this cycle is absorbed);
        // otherwise a request on this cycle is remembered for IDLE.
        if (pending) begin
          state_next   = S_LATCH;
          pending_next = 1'b0;
        end else begin
          state_next   = S_IDLE;
          pending_next = req;
        end
      end
      default: begin
        state_next   = S_IDLE;
        cnt_next     = '0;
        bit_cnt_next = 3'd0;
        pending_next = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial sampling
  // --------------------------------------------------------------------------
  // Bit 0 (A) is valid as soon as the latch is released; later bits are
  // taken at the end of the clock-high phase, long after the controller
  // shifted on the rising edge.
  assign sample_a   = (state == S_WAIT_A)   && (cnt == '0);
  assign sample_bit = (state == S_SHIFT_HI) && (cnt == HALF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp0 <= 8'h00;
      samp1 <= 8'h00;
    end else if (sample_a) begin
      samp0[0] <= sync0[1];
      samp1[0] <= sync1[1];
    end else if (sample_bit) begin
      samp0[bit_cnt] <= sync0[1];
      samp1[bit_cnt] <= sync1[1];
    end
  end

  // An all-zero capture means the line is stuck low: no controller plugged in.
  assign new_btn0 = (|samp0) ? ~samp0 : 8'h00;
  assign new_btn1 = (|samp1) ? ~samp1 : 8'h00;

  // --------------------------------------------------------------------------
  // Registered outputs (one cycle behind the state decode)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nes_latch  <= 1'b0;
      nes_clk    <= 1'b0;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      buttons0   <= 8'h00;
      buttons1   <= 8'h00;
      pressed0   <= 8'h00;
      pressed1   <= 8'h00;
      present    <= 2'b00;
    end else begin
      nes_latch  <= (state == S_LATCH);
      nes_clk    <= (state == S_SHIFT_HI);
      busy       <= (state != S_IDLE);
      snap_valid <= (state == S_PUBLISH);
      if (state == S_PUBLISH) begin
        buttons0 <= new_btn0;
        buttons1 <= new_btn1;
        pressed0 <= new_btn0 & ~buttons0;
        pressed1 <= new_btn1 & ~buttons1;
        present  <= {|samp1, |samp0};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_poll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_poll_scheduler
// Purpose  : Directed self-checking bench for nes_poll_scheduler. Two
//            behavioural 4021-style controller models drive the data lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_poll_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       poll_req = 1'b0;
  logic       nes_data0;
  logic       nes_data1;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons0, buttons1, pressed0, pressed1;
  logic [1:0] present;
  logic       snap_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  nes_poll_scheduler #(
    .LATCH_CYCLES    (600),
    .HALF_BIT_CYCLES (300),
    .POLL_PERIOD     (10000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .poll_req   (poll_req),
    .nes_data0  (nes_data0),
    .nes_data1  (nes_data1),
    .nes_latch  (nes_latch),
    .nes_clk    (nes_clk),
    .buttons0   (buttons0),
    .buttons1   (buttons1),
    .pressed0   (pressed0),
    .pressed1   (pressed1),
    .present    (present),
    .snap_valid (snap_valid),
    .busy       (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller models: active-low button patterns, parallel load on latch,
  // shift on rising nes_clk, serial 1s after the eighth bit.
  logic [7:0] pat0 = 8'hFF;
  logic [7:0] pat1 = 8'hFF;
  logic [7:0] sr0  = 8'hFF;
  logic [7:0] sr1  = 8'hFF;
  logic       tie1 = 1'b0;

  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) begin
      sr0 <= pat0;
      sr1 <= pat1;
    end else begin
      sr0 <= {1'b1, sr0[7:1]};
      sr1 <= {1'b1, sr1[7:1]};
    end
  end

  assign nes_data0 = sr0[0];
  assign nes_data1 = tie1 ? 1'b0 : sr1[0];

  // Bus monitor: edge numbers of strobes / latch rises, running counters.
  int   snap_q[$];
  int   lrise_q[$];
  int   latch_hi_cnt = 0;
  int   clk_rise_cnt = 0;
  logic latch_d = 1'b0;
  logic clk_d   = 1'b0;

  always @(negedge clk) begin
    if (snap_valid === 1'b1) snap_q.push_back(cyc);
    if (nes_latch === 1'b1 && latch_d === 1'b0) lrise_q.push_back(cyc);
    if (nes_latch === 1'b1) latch_hi_cnt <= latch_hi_cnt + 1;
    if (nes_clk === 1'b1 && clk_d === 1'b0) clk_rise_cnt <= clk_rise_cnt + 1;
    latch_d <= nes_latch;
    clk_d   <= nes_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pulse poll_req for one cycle; e returns the edge that samples it.
  task automatic pulse_req(output int e);
    tick();
    poll_req = 1'b1;
    e = cyc + 1;
    tick();
    poll_req = 1'b0;
  endtask

  // One full poll from IDLE with bus timing checks.
  task automatic run_poll();
    int e, n0, lr0, lh0, cr0;
    n0  = snap_q.size();
    lr0 = lrise_q.size();
    lh0 = latch_hi_cnt;
    cr0 = clk_rise_cnt;
    pulse_req(e);
    for (int i = 0; i < 6000 && snap_q.size() == n0; i++) tick();
    if (snap_q.size() == n0) begin
      check("snap_timeout", 32'd0, 32'd1);
    end else begin
      check("snap_latency", snap_q[n0] - e, 5101);
      check("latch_rise", (lrise_q.size() > lr0) ? lrise_q[lr0] - e : -1, 1);
      check("latch_len", latch_hi_cnt - lh0, 600);
      check("clk_pulses", clk_rise_cnt - cr0, 7);
      repeat (3) tick();
      check("snap_one_cycle", snap_q.size() - n0, 1);
      check("busy_after", busy, 1'b0);
    end
  endtask

  initial begin
    int e, n0, lr0;

    reset_n = 1'b0;
    repeat (4) tick();
    check("rst_latch", nes_latch, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_snap", snap_valid, 1'b0);
    check("rst_present", present, 2'b00);
    check("rst_buttons0", buttons0, 8'h00);
    reset_n = 1'b1;

`ifdef NES_AUTOPOLL_EN
    begin
      int rel;
      rel = cyc;
      for (int i = 0; i < 30000 && snap_q.size() < 2; i++) tick();
      if (snap_q.size() < 2) begin
        check("auto_timeout", 32'd0, 32'd1);
      end else begin
        check("auto_first", snap_q[0] - rel, 15101);
        check("auto_period", snap_q[1] - snap_q[0], 10000);
      end
    end
`else
    repeat (5) tick();

    // A and up pressed on port 0, nothing on port 1.
    pat0 = 8'hEE; pat1 = 8'hFF;
    run_poll();
    check("p1_buttons0", buttons0, 8'h11);
    check("p1_pressed0", pressed0, 8'h11);
    check("p1_buttons1", buttons1, 8'h00);
    check("p1_pressed1", pressed1, 8'h00);
    check("p1_present", present, 2'b11);

    // Same data again: no new edges.
    run_poll();
    check("p2_buttons0", buttons0, 8'h11);
    check("p2_pressed0", pressed0, 8'h00);

    // Release A, press B; port 1 presses A and right.
    pat0 = 8'hED; pat1 = 8'h7E;
    run_poll();
    check("p3_buttons0", buttons0, 8'h12);
    check("p3_pressed0", pressed0, 8'h02);
    check("p3_buttons1", buttons1, 8'h81);
    check("p3_pressed1", pressed1, 8'h81);

    // Requests during a running poll collapse into one follow-on poll.
    n0  = snap_q.size();
    lr0 = lrise_q.size();
    pulse_req(e);
    while (cyc < e + 1000) tick();
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    while (cyc < e + 2000) tick();
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    for (int i = 0; i < 12000 && snap_q.size() < n0 + 2; i++) tick();
    repeat (400) tick();
    check("b2b_count", snap_q.size() - n0, 2);
    if (snap_q.size() >= n0 + 2 && lrise_q.size() >= lr0 + 2) begin
      check("b2b_first", snap_q[n0] - e, 5101);
      check("b2b_second", snap_q[n0 + 1] - snap_q[n0], 5101);
      check("b2b_latch", lrise_q[lr0 + 1] - snap_q[n0], 1);
    end else begin
      check("b2b_missing", 32'd0, 32'd1);
    end

    // Port 1 line stuck low: not present, zero buttons and edges.
    tie1 = 1'b1;
    run_poll();
    check("nc_present", present, 2'b01);
    check("nc_buttons1", buttons1, 8'h00);
    check("nc_pressed1", pressed1, 8'h00);
    check("nc_buttons0", buttons0, 8'h12);
    run_poll();
    check("nc2_present", present, 2'b01);
    check("nc2_pressed1", pressed1, 8'h00);

    // Reset in the middle of a shift-clock high phase.
    tie1 = 1'b0;
    n0 = snap_q.size();
    pulse_req(e);
    while (cyc < e + 2950) tick();
    check("pre_rst_clk", nes_clk, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_latch", nes_latch, 1'b0);
    check("mid_rst_clk", nes_clk, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (5) tick();
    check("mid_rst_buttons0", buttons0, 8'h00);
    check("mid_rst_present", present, 2'b00);
    reset_n = 1'b1;
    repeat (6000) tick();
    check("mid_rst_no_snap", snap_q.size() - n0, 0);

    // Fresh poll after reset: history cleared, so every held button is a press.
    pat0 = 8'hEE; pat1 = 8'hFF;
    run_poll();
    check("post_buttons0", buttons0, 8'h11);
    check("post_pressed0", pressed0, 8'h11);
    check("post_present", present, 2'b11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
